drum_step_sequencer: RTL

//  Master scheduler for the drum machine: holds a TRACKS x STEPS on/off pattern, advances a step pointer at a

---
 rtl/drum_step_sequencer_pkg.sv | 24 ++
 rtl/drum_step_sequencer_if.sv | 20 ++
 rtl/drum_step_sequencer_step_timer.sv | 62 ++++++
 rtl/drum_step_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/drum_step_sequencer_pkg.sv
// ============================================================================
// drum_seq_pkg : shared types and constants for the drum step sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package drum_seq_pkg;

   typedef enum logic [0:0] {
      SEQ_IDLE = 1'b0,
      SEQ_RUN  = 1'b1
   } seq_state_e;

   localparam logic [23:0] DEFAULT_TEMPO_DIV = 24'd12500000;
   localparam logic [23:0] MIN_DIV           = 24'd2;

   // Divisors below MIN_DIV would make a step shorter than the tick pipeline.
   function automatic logic [23:0] eff_div(input logic [23:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

`default_nettype wire

// File: rtl/drum_step_sequencer_if.sv
// ============================================================================
// drum_step_sequencer_if : pattern-edit bus from the UI into the sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface drum_step_sequencer_if #(
   parameter int TRACKS = 4,
   parameter int STEPS  = 16
);
   logic                       edit_we;
   logic [$clog2(TRACKS)-1:0]  edit_track;
   logic [$clog2(STEPS)-1:0]   edit_step;
   logic                       edit_val;

   modport master (output edit_we, output edit_track, output edit_step, output edit_val);
   modport slave  (input  edit_we, input  edit_track, input  edit_step, input  edit_val);
endinterface

`default_nettype wire

// File: rtl/drum_step_sequencer_step_timer.sv
// ============================================================================
// step_timer : per-step clock counter, signals the last clock of each step.
// Optional swing via `define DRUM_SEQ_SWING_EN. Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module step_timer
   import drum_seq_pkg::*;
#(
   parameter int SWING_CLKS = 0
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        clear_i,
   input  wire logic        odd_step_i,
   input  wire logic [23:0] tempo_div_i,
   output logic             step_end_o
);
   logic [24:0] cnt_q;
   logic [24:0] cnt_d;
   logic [24:0] w_eff;
   logic [24:0] w_len;

   assign w_eff = {1'b0, eff_div(tempo_div_i)};

`ifdef DRUM_SEQ_SWING_EN
   localparam logic [24:0] c_SWING = 25'(SWING_CLKS);

   // Odd steps give back what even steps borrowed, but never drop below 2 clocks.
   always_comb begin
      w_len = w_eff + c_SWING;
      if (odd_step_i) begin
         w_len = (w_eff >= c_SWING + 25'd2) ? (w_eff - c_SWING) : 25'd2;
      end
   end
`else
   logic w_unused_swing;
   assign w_unused_swing = odd_step_i ^ (SWING_CLKS != 0);
   assign w_len          = w_eff;
`endif

   // ">=" lets a mid-step tempo decrease end the step on the next clock.
   assign step_end_o = (cnt_q >= (w_len - 25'd1));

   always_comb begin
      cnt_d = cnt_q + 25'd1;
      if (clear_i || step_end_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/drum_step_sequencer.sv
// ============================================================================
// drum_step_sequencer : TRACKS x STEPS pattern scheduler issuing trig/gate.
// Optional swing: `define DRUM_SEQ_SWING_EN. Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module drum_step_sequencer
   import drum_seq_pkg::*;
#(
   parameter int TRACKS     = 4,
   parameter int STEPS      = 16,
   parameter int SWING_CLKS = 0
) (
   input  wire logic                      CLOCK_50,
   input  wire logic                      reset,
   input  wire logic                      play,
   input  wire logic [23:0]               tempo_div,
   drum_step_sequencer_if.slave           edit,
   output logic [$clog2(STEPS)-1:0]       step_idx,
   output logic                           step_tick,
   output logic [TRACKS-1:0]              trig,
   output logic [TRACKS-1:0]              gate,
   output logic                           running
);
   localparam int c_TW = $clog2(TRACKS);
   localparam int c_SW = $clog2(STEPS);

   seq_state_e                    state_q, state_d;
   logic [c_SW-1:0]               step_q, step_d;
   logic                          tick_q, tick_d;
   logic [TRACKS-1:0]             trig_q, trig_d;
   logic [TRACKS-1:0]             gate_q, gate_d;
   logic [TRACKS-1:0][STEPS-1:0]  pattern_q, pattern_d;

   logic                          w_step_end;
   logic                          w_clear;
   logic                          w_trk_ok;
   logic [c_SW-1:0]               w_sel;
   logic [TRACKS-1:0]             w_col;

   generate
      if ((1 << c_TW) == TRACKS) begin : g_trk_pow2
         assign w_trk_ok = 1'b1;
      end else begin : g_trk_range
         assign w_trk_ok = (edit.edit_track < c_TW'(TRACKS));
      end
   endgenerate

   assign w_clear = (state_q != SEQ_RUN) || !play;

   step_timer #(
      .SWING_CLKS (SWING_CLKS)
   ) u_step_timer (
      .clk         (CLOCK_50),
      .reset       (reset),
      .clear_i     (w_clear),
      .odd_step_i  (step_q[0]),
      .tempo_div_i (tempo_div),
      .step_end_o  (w_step_end)
   );

   // Column of the step about to start; reads the pre-write pattern.
   always_comb begin
      w_sel = (state_q == SEQ_RUN) ? (step_q + 1'b1) : '0;
      w_col = '0;
      for (int t = 0; t < TRACKS; t++) begin
         w_col[t] = pattern_q[t][w_sel];
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      tick_d    = 1'b0;
      trig_d    = '0;
      gate_d    = gate_q;
      pattern_d = pattern_q;

      if (edit.edit_we && w_trk_ok) begin
         pattern_d[edit.edit_track][edit.edit_step] = edit.edit_val;
      end

      case (state_q)
         SEQ_IDLE: begin
            step_d = '0;
            gate_d = '0;
            if (play) begin
               state_d = SEQ_RUN;
               tick_d  = 1'b1;
               trig_d  = w_col;
               gate_d  = w_col;
            end
         end
         SEQ_RUN: begin
            if (!play) begin
               state_d = SEQ_IDLE;
               step_d  = '0;
               gate_d  = '0;
            end else if (w_step_end) begin
               step_d = step_q + 1'b1;
               tick_d = 1'b1;
               trig_d = w_col;
               gate_d = w_col;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
            step_d  = '0;
            gate_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q   <= SEQ_IDLE;
         step_q    <= '0;
         tick_q    <= 1'b0;
         trig_q    <= '0;
         gate_q    <= '0;
         pattern_q <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         tick_q    <= tick_d;
         trig_q    <= trig_d;
         gate_q    <= gate_d;
         pattern_q <= pattern_d;
      end
   end

   assign step_idx  = step_q;
   assign step_tick = tick_q;
   assign trig      = trig_q;
   assign gate      = gate_q;
   assign running   = (state_q == SEQ_RUN);

endmodule

`default_nettype wire
